// File: rtl/runway_scheduler.sv
// Shared-runway arbiter: round-robin grant between arrival and departure,
// fixed occupancy plus clearance window, drives the airport wind/pattern select.
module runway_scheduler #(
    parameter int OCCUPY_CYCLES = 8,
    parameter int CLEAR_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arr_req,
    input  logic       dep_req,
    input  logic [1:0] wind,
    output logic       arr_gnt,
    output logic       dep_gnt,
    output logic       busy,
    output logic [1:0] w_out,
    output logic [1:0] state
);
    localparam int MAXC = (OCCUPY_CYCLES > CLEAR_CYCLES) ? OCCUPY_CYCLES : CLEAR_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] OCC_LOAD = CW'(OCCUPY_CYCLES - 1);
    localparam logic [CW-1:0] CLR_LOAD = CW'(CLEAR_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        GRANT    = 2'b01,
        OCCUPIED = 2'b10,
        CLEAR    = 2'b11
    } state_t;

    state_t        cur, nxt;
    logic [CW-1:0] cnt, cnt_n;
    logic          last_dep, last_dep_n;
    logic [1:0]    lw, lw_n;
    logic          arr_gnt_n, dep_gnt_n, busy_n;
    logic [1:0]    w_out_n;

    always_comb begin
        nxt        = cur;
        cnt_n      = cnt;
        last_dep_n = last_dep;
        lw_n       = lw;
        case (cur)
            IDLE: begin
                if (wind != 2'b11 && (arr_req || dep_req)) begin
                    nxt        = GRANT;
                    lw_n       = wind;
                    // on a tie, serve whoever was not served last
                    last_dep_n = !(arr_req && (!dep_req || last_dep));
                end
            end
            GRANT: begin
                nxt   = OCCUPIED;
                cnt_n = OCC_LOAD;
            end
            OCCUPIED: begin
                if (cnt == '0) begin
                    nxt   = CLEAR;
                    cnt_n = CLR_LOAD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            CLEAR: begin
                if (cnt == '0) nxt = IDLE;
                else           cnt_n = cnt - 1'b1;
            end
            default: nxt = IDLE;
        endcase

        // outputs are registered from the next state so they line up with it
        arr_gnt_n = (nxt == GRANT) && !last_dep_n;
        dep_gnt_n = (nxt == GRANT) &&  last_dep_n;
        busy_n    = (nxt != IDLE);
        w_out_n   = (nxt == GRANT || nxt == OCCUPIED) ? lw_n : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur      <= IDLE;
            cnt      <= '0;
            last_dep <= 1'b1;
            lw       <= 2'b00;
            arr_gnt  <= 1'b0;
            dep_gnt  <= 1'b0;
            busy     <= 1'b0;
            w_out    <= 2'b00;
        end else begin
            cur      <= nxt;
            cnt      <= cnt_n;
            last_dep <= last_dep_n;
            lw       <= lw_n;
            arr_gnt  <= arr_gnt_n;
            dep_gnt  <= dep_gnt_n;
            busy     <= busy_n;
            w_out    <= w_out_n;
        end
    end

    assign state = cur;
endmodule

// File: tb/tb_runway_scheduler.sv
// Scoreboard bench: a timeline model predicts every cycle's outputs; a negedge
// monitor pops and compares them against the scheduler.
module tb_runway_scheduler;
    localparam int OCC = 8;
    localparam int CLR = 2;

    logic       clk = 1'b0;
    logic       reset, arr_req, dep_req;
    logic [1:0] wind;
    logic       arr_gnt, dep_gnt, busy;
    logic [1:0] w_out, state;

    runway_scheduler #(.OCCUPY_CYCLES(OCC), .CLEAR_CYCLES(CLR)) dut (
        .clk(clk), .reset(reset), .arr_req(arr_req), .dep_req(dep_req), .wind(wind),
        .arr_gnt(arr_gnt), .dep_gnt(dep_gnt), .busy(busy), .w_out(w_out), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ag;
        logic       dg;
        logic       busy;
        logic [1:0] w;
        logic [1:0] st;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Model: an operation is a time window starting at the grant cycle g.
    // Offset 0 is the grant, 1..OCC occupied, OCC+1..OCC+CLR clearance;
    // the runway may be granted again once OCC+CLR+2 cycles have elapsed.
    int         k = 0;
    int         g = 0;
    bit         active = 0;
    bit         last_dep = 1;
    logic [1:0] lw = 2'b00;

    always @(posedge clk) begin
        exp_t e;
        bit   free, pick_arr;
        int   d;
        e = '0;
        if (reset) begin
            active   = 0;
            last_dep = 1;
        end else begin
            d    = k - g;
            free = !active || (d >= OCC + CLR + 2);
            if (free && wind != 2'b11 && (arr_req || dep_req)) begin
                pick_arr = arr_req && (!dep_req || last_dep);
                active   = 1;
                g        = k;
                last_dep = !pick_arr;
                lw       = wind;
                e.ag = pick_arr; e.dg = !pick_arr; e.busy = 1; e.w = lw; e.st = 2'd1;
            end else if (active && d >= 1 && d <= OCC) begin
                e.busy = 1; e.w = lw; e.st = 2'd2;
            end else if (active && d > OCC && d <= OCC + CLR) begin
                e.busy = 1; e.st = 2'd3;
            end
        end
        q.push_back(e);
        k++;
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if ({arr_gnt, dep_gnt, busy, w_out, state} !== e) begin
                fails++;
                $display("FAIL cycle_outputs cyc=%0d got ag=%b dg=%b busy=%b w=%b st=%b want ag=%b dg=%b busy=%b w=%b st=%b",
                         k - 1, arr_gnt, dep_gnt, busy, w_out, state, e.ag, e.dg, e.busy, e.w, e.st);
            end
        end
    end

    task automatic drive(input logic a, input logic d, input logic [1:0] w, input logic r, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            arr_req = a; dep_req = d; wind = w; reset = r;
        end
    endtask

    task automatic chk_idle(input string name);
        tests++;
        if ({arr_gnt, dep_gnt, busy, w_out, state} !== 7'b0) begin
            fails++;
            $display("FAIL %s got ag=%b dg=%b busy=%b w=%b st=%b want all zero",
                     name, arr_gnt, dep_gnt, busy, w_out, state);
        end
    endtask

    initial begin
        reset = 1'b1; arr_req = 1'b0; dep_req = 1'b0; wind = 2'b00;
        drive(0, 0, 2'b00, 1, 3);
        chk_idle("reset_state");
        // single arrival, wind right-to-left, full window
        drive(1, 0, 2'b01, 0, 2);
        drive(0, 0, 2'b01, 0, 14);
        // tie after reset: arrival first, then alternate
        drive(0, 0, 2'b00, 1, 1);
        drive(1, 1, 2'b10, 0, 50);
        drive(0, 0, 2'b00, 0, 14);
        // storm blocks departure, calm releases it
        drive(0, 1, 2'b11, 0, 20);
        chk_idle("storm_wait_expired");
        drive(0, 1, 2'b00, 0, 2);
        drive(0, 0, 2'b00, 0, 12);
        // wind change mid-occupancy is not seen on w_out
        drive(1, 0, 2'b01, 0, 2);
        drive(0, 0, 2'b10, 0, 14);
        // reset during occupancy with arrival still requesting
        drive(1, 0, 2'b01, 0, 6);
        drive(1, 0, 2'b01, 1, 1);
        drive(1, 0, 2'b01, 0, 3);
        drive(0, 0, 2'b00, 0, 12);
        // departure pulse inside clearance only
        drive(1, 0, 2'b00, 0, 2);
        drive(0, 0, 2'b00, 0, 8);
        drive(0, 1, 2'b00, 0, 1);
        drive(0, 0, 2'b00, 0, 15);

        // random traffic: requesters hold until granted, sometimes give up
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (arr_gnt) arr_req = 1'b0;
            else if (!arr_req) arr_req = ($urandom_range(0, 5) == 0);
            else if ($urandom_range(0, 40) == 0) arr_req = 1'b0;
            if (dep_gnt) dep_req = 1'b0;
            else if (!dep_req) dep_req = ($urandom_range(0, 5) == 0);
            else if ($urandom_range(0, 40) == 0) dep_req = 1'b0;
            if ($urandom_range(0, 7) == 0) wind = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 199) == 0);
        end
        drive(0, 0, 2'b00, 0, 3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/runway_scheduler.md
# runway_scheduler

Shared-runway controller that arbitrates between an arrival requester and a departure requester, holds the runway for a fixed occupancy window plus a clearance gap, and drives the 2-bit wind/pattern select of the `airport` runway-light FSM. It sits between the switch/key inputs and `airport` in the `DE1_SoC` top level. It runs on a `clock_divider` tap, so all counts below are in divided-clock cycles.

## Interface
- `OCCUPY_CYCLES`, default 8, cycles the runway stays occupied after a grant (≥1).
- `CLEAR_CYCLES`, default 2, clearance gap before the next grant (≥1).
- `clk`  in  1  system clock. The only clock: one clock; reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high reset, sampled on posedge `clk`.
- `arr_req`  in  1  arrival request, level; requester holds it until it sees `arr_gnt`.
- `dep_req`  in  1  departure request, level; same rule.
- `wind`  in  2  live wind: 00 calm, 01 right-to-left, 10 left-to-right, 11 storm (no operations).
- `arr_gnt`  out  1  one-cycle grant pulse to arrival.
- `dep_gnt`  out  1  one-cycle grant pulse to departure.
- `busy`  out  1  runway not free (GRANT, OCCUPIED or CLEAR).
- `w_out`  out  2  pattern select to `airport`'s `w`.
- `state`  out  2  debug: 00 IDLE, 01 GRANT, 10 OCCUPIED, 11 CLEAR.

## Operation
- All outputs are registered. Reset values: `state`=IDLE, `arr_gnt`=0, `dep_gnt`=0, `busy`=0, `w_out`=00, counter=0, `last_served`=departure, latched wind=00.
- IDLE: if `wind`==11, no grant; stay in IDLE. Otherwise:
  - Only `arr_req` → grant arrival. Only `dep_req` → grant departure.
  - Both asserted → grant the one not in `last_served`. Round-robin, so arrival wins the first tie after reset.
  - On any grant: latch `wind`, update `last_served`, go to GRANT.
- GRANT, exactly 1 cycle: the matching `*_gnt`=1 and `busy`=1. Then go to OCCUPIED with counter loaded to `OCCUPY_CYCLES`-1.
- OCCUPIED: decrement each cycle. At counter==0 go to CLEAR with counter loaded to `CLEAR_CYCLES`-1.
- CLEAR: decrement each cycle. At counter==0 go to IDLE.
- `w_out`:
  - In GRANT and OCCUPIED: the latched wind.
  - In IDLE and CLEAR: 00 (calm pattern).
  - Never 11.
- Requests are ignored outside IDLE. A request held through a busy window is serviced in IDLE.
- A request dropped before its grant is simply not serviced. No queueing.
- `wind` changes after the grant do not affect the current operation.
- Counter width is $clog2(max(OCCUPY_CYCLES,CLEAR_CYCLES)). The counter never wraps: it is loaded on entry and stops at 0.
- Reset asserted in any state returns every output to its reset value on the next edge and aborts the operation in progress. No grant pulse is issued on that edge.

## Timing
- Request and wind sampled high in IDLE at edge t → GRANT at t+1 (`*_gnt`=1, `busy`=1, `w_out`=latched wind).
- OCCUPIED for edges t+2 … t+1+`OCCUPY_CYCLES`.
- CLEAR for the next `CLEAR_CYCLES` edges.
- IDLE at t+2+`OCCUPY_CYCLES`+`CLEAR_CYCLES`. The earliest next grant is one edge later.
- Grant period with continuous requests: `OCCUPY_CYCLES`+`CLEAR_CYCLES`+2 cycles (12 at defaults).
- `arr_gnt` and `dep_gnt` are never high together. Each pulses for exactly one cycle per operation.
- `busy`=1 exactly when `state`≠IDLE.

## Test plan
- Reset, then `arr_req`=1 and `wind`=01 held → `arr_gnt` pulses 1 cycle after the request is seen. `w_out`=01 for 9 cycles, then 00. `busy`=1 for 11 cycles. `state` goes 01, 10×8, 11×2, 00.
- After reset, `arr_req`=`dep_req`=1 held with `wind`=10 → grants in the order arr, dep, arr, dep, each 12 cycles apart. Never both at once.
- `dep_req` held with `wind`=11 for 20 cycles → no grant, `busy`=0, `w_out`=00. Set `wind`=00 → `dep_gnt` on the next cycle.
- Grant with `wind`=01, then switch `wind` to 10 during OCCUPIED → `w_out` stays 01 until CLEAR.
- Assert `reset` for 1 cycle at occupancy cycle 4 with `arr_req` still high → all outputs return to reset values. A new `arr_gnt` is issued 2 cycles after `reset` falls.
- `dep_req` pulsed for 1 cycle during CLEAR only → no `dep_gnt` ever issued.
